heard_indication_serializer: RTL

- Downstream stage of the 10-way vector responder; consumes its heard(meth, v) indication.
- Buffers indications in a small FIFO.
- Emits each indication as a 2-word message (header, then payload) on a 32-bit ENA/RDY stream toward the host portal.

---
 rtl/heard_indication_serializer_pkg.sv | 36 +++
 rtl/heard_indication_serializer_fifo.sv | 69 ++++++
 rtl/heard_indication_serializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/heard_indication_serializer_pkg.sv
// Shared types and header layout for the heard-indication serializer.
// Optional macro HEARD_SER_SEQNUM_EN enables the header sequence number.
package heard_indication_serializer_pkg;

  localparam int NUM_METH_DEF = 10;

  localparam int FIELD_W  = 8;
  localparam int METH_LSB = 0;
  localparam int LEN_LSB  = 16;
  localparam int SEQ_LSB  = 24;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } ser_state_e;

  typedef struct packed {
    logic [7:0]  meth;
    logic [31:0] v;
  } heard_entry_t;

  localparam int ENTRY_W = $bits(heard_entry_t);

  function automatic logic [31:0] make_header(input logic [7:0] meth,
                                              input logic [7:0] len,
                                              input logic [7:0] seq);
    logic [31:0] h;
    h = '0;
    h[METH_LSB +: FIELD_W] = meth;
    h[LEN_LSB  +: FIELD_W] = len;
    h[SEQ_LSB  +: FIELD_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/heard_indication_serializer_fifo.sv
// Generic synchronous FIFO with same-cycle push/pop and a look-ahead port
// exposing the entry behind the head. Synchronous active-low reset.
module heard_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign next_data = mem_q[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/heard_indication_serializer.sv
// Buffers heard(meth, v) indications and emits each as a header+payload pair
// on a 32-bit ENA/RDY stream. Optional macro: HEARD_SER_SEQNUM_EN.
module heard_indication_serializer
  import heard_indication_serializer_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int NUM_METH      = NUM_METH_DEF,
  parameter int PAYLOAD_WORDS = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        msg__ENA,
  output logic [31:0] msg_data,
  input  logic        msg__RDY,
  output logic [15:0] drop_count,
  output logic [31:0] msg_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] LEN = 8'(PAYLOAD_WORDS);

  heard_entry_t push_entry, head_entry, next_entry, cand_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          meth_ok, accept, push, pop;

  ser_state_e  state_q, state_d;
  logic        msg_ena_q, msg_ena_d;
  logic [31:0] msg_data_q, msg_data_d;
  logic [15:0] drop_q, drop_d;
  logic [31:0] msg_cnt_q, msg_cnt_d;
  logic [7:0]  seq_now, seq_next;

  assign push_entry = '{meth: heard_meth[7:0], v: heard_v};
  assign meth_ok    = (heard_meth < 32'(NUM_METH));
  assign heard__RDY = nRST && !fifo_full;
  assign accept     = heard__ENA && heard__RDY;
  assign push       = accept && meth_ok;
  assign pop        = (state_q == PAY) && msg__RDY;

  heard_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .next_data (next_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef HEARD_SER_SEQNUM_EN
  logic [7:0] seq_q, seq_d;

  assign seq_d    = pop ? seq_q + 8'd1 : seq_q;
  assign seq_now  = seq_q;
  assign seq_next = seq_q + 8'd1;

  always_ff @(posedge CLK) begin
    if (!nRST) seq_q <= '0;
    else       seq_q <= seq_d;
  end
`else
  assign seq_now  = '0;
  assign seq_next = '0;
`endif

  // While leaving PAY the next header comes from the entry behind the head,
  // or from the indication being pushed this cycle if the FIFO drains to it.
  always_comb begin
    cand_entry = head_entry;
    if (state_q == PAY) begin
      cand_entry = (fifo_count > CW'(1)) ? next_entry : push_entry;
    end
  end

  always_comb begin
    state_d    = state_q;
    msg_ena_d  = msg_ena_q;
    msg_data_d = msg_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = HDR;
          msg_ena_d  = 1'b1;
          msg_data_d = make_header(cand_entry.meth, LEN, seq_now);
        end
      end
      HDR: begin
        if (msg__RDY) begin
          state_d    = PAY;
          msg_data_d = cand_entry.v;
        end
      end
      PAY: begin
        if (msg__RDY) begin
          if (fifo_count > CW'(1) || push) begin
            state_d    = HDR;
            msg_data_d = make_header(cand_entry.meth, LEN, seq_next);
          end else begin
            state_d    = IDLE;
            msg_ena_d  = 1'b0;
            msg_data_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        msg_ena_d  = 1'b0;
        msg_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      msg_ena_q  <= 1'b0;
      msg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      msg_ena_q  <= msg_ena_d;
      msg_data_q <= msg_data_d;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && !meth_ok && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    msg_cnt_d = pop ? msg_cnt_q + 32'd1 : msg_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      drop_q    <= '0;
      msg_cnt_q <= '0;
    end else begin
      drop_q    <= drop_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  // Stream outputs are forced quiet for as long as reset is held.
  assign msg__ENA   = nRST && msg_ena_q;
  assign msg_data   = nRST ? msg_data_q : '0;
  assign drop_count = drop_q;
  assign msg_count  = msg_cnt_q;

endmodule
